if_fetch_unit: RTL and testbench

Instruction-fetch stage: owns the PC, selects the next PC, and fetches from instruction memory over a req/ack handshake that may take several cycles. It drives if_pc4 and if_inst into the IF/ID pipeline register. Its fetch_stall output is ORed into that register's stall, so IF/ID holds while a fetch is outstanding. Branches and jumps use delay-slot semantics, so nothing is squashed.

---
 rtl/if_fetch_unit.sv | 157 +++++++++++++++
 tb/tb_if_fetch_unit.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction-fetch stage with PC, next-PC select and req/ack imem fetch
//
// Purpose: owns the PC, fetches from instruction memory over a multi-cycle
// req/ack handshake and presents the fetched word to the IF/ID register.
// Branches and jumps use delay-slot semantics, so nothing is ever squashed.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   clrn         synchronous active-low reset
//   stall        hazard-unit stall (hold PC and the delivered instruction)
//   pcsrc        next-PC select: 00 pc+4, 01 bpc, 10 rpc, 11 jpc
//   bpc/rpc/jpc  branch, register-jump and jump targets
//   imem_req     fetch request
//   imem_addr    fetch address (the PC register)
//   imem_ack     memory returns data this cycle
//   imem_rdata   instruction word, valid with imem_ack
//   if_pc4       PC+4 of the instruction on if_inst
//   if_inst      delivered instruction
//   fetch_stall  1 while if_inst is not valid; IF/ID must not load
//   fetch_err    sticky fetch-timeout flag, cleared only by reset

module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        stall,
  input  logic [1:0]  pcsrc,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc4,
  output logic [31:0] if_inst,
  output logic        fetch_stall,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] RESET_PC_A = RESET_PC & ALIGN_MASK;
  localparam logic [7:0]  WAIT_LAST  = 8'(TIMEOUT - 1);

  state_t      state;
  logic [31:0] pc;
  logic [31:0] inst_buf;
  logic [7:0]  wait_cnt;

  logic [31:0] pc4;
  logic [31:0] npc_raw;
  logic [31:0] npc;
  logic        timeout;
  logic        done;

  assign pc4 = pc + 32'd4;

  // Targets are masked so pc[1:0] stays 00 whatever ID hands us.
  always_comb begin
    npc_raw = pc4;
    case (pcsrc)
      2'b00:   npc_raw = pc4;
      2'b01:   npc_raw = bpc;
      2'b10:   npc_raw = rpc;
      default: npc_raw = jpc;
    endcase
  end

  assign npc = npc_raw & ALIGN_MASK;

  // A timeout is the last permitted wait cycle with no ack; it completes
  // the fetch as if the memory had returned NOP_INST.
  assign timeout = (state == FETCH) && !imem_ack && (wait_cnt == WAIT_LAST);
  assign done    = (state == FETCH) && (imem_ack || timeout);

  always_comb begin
    imem_req    = (state == FETCH);
    imem_addr   = pc;
    if_pc4      = pc4;
    if_inst     = NOP_INST;
    fetch_stall = 1'b1;
    case (state)
      IDLE: begin
        if_inst     = NOP_INST;
        fetch_stall = 1'b1;
      end
      FETCH: begin
        // Ack data is passed straight through so zero-wait memory
        // sustains one instruction per cycle.
        if_inst     = imem_ack ? imem_rdata : NOP_INST;
        fetch_stall = !done;
      end
      HOLD: begin
        if_inst     = inst_buf;
        fetch_stall = 1'b0;
      end
      default: begin
        if_inst     = NOP_INST;
        fetch_stall = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state     <= IDLE;
      pc        <= RESET_PC_A;
      wait_cnt  <= 8'd0;
      fetch_err <= 1'b0;
      inst_buf  <= NOP_INST;
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          wait_cnt <= 8'd0;
        end
        FETCH: begin
          if (done) begin
            wait_cnt <= 8'd0;
            if (timeout) begin
              fetch_err <= 1'b1;
            end
            if (stall) begin
              inst_buf <= imem_ack ? imem_rdata : NOP_INST;
              state    <= HOLD;
            end else begin
              pc <= npc;
            end
          end else begin
            // Stall before ack has no effect: keep requesting the same PC.
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        HOLD: begin
          wait_cnt <= 8'd0;
          if (!stall) begin
            pc    <= npc;
            state <= FETCH;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - self-checking bench for if_fetch_unit

module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        clrn;
  logic        stall;
  logic [1:0]  pcsrc;
  logic [31:0] bpc, rpc, jpc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] if_pc4;
  logic [31:0] if_inst;
  logic        fetch_stall;
  logic        fetch_err;

  int errors = 0;
  int checks = 0;

  if_fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .NOP_INST(NOP),
    .TIMEOUT (16)
  ) dut (
    .clk        (clk),
    .clrn       (clrn),
    .stall      (stall),
    .pcsrc      (pcsrc),
    .bpc        (bpc),
    .rpc        (rpc),
    .jpc        (jpc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .if_pc4     (if_pc4),
    .if_inst    (if_inst),
    .fetch_stall(fetch_stall),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench one step after reset release: first FETCH cycle.
  task automatic do_reset;
    clrn = 1'b0; stall = 1'b0; pcsrc = 2'b00; imem_ack = 1'b0;
    imem_rdata = 32'h0; bpc = 32'h0; rpc = 32'h0; jpc = 32'h0;
    step;
    clrn = 1'b1;
    step;
  endtask

  task automatic test_reset;
    clrn = 1'b0; stall = 1'b0; pcsrc = 2'b00; imem_ack = 1'b1;
    imem_rdata = 32'hFFFF_FFFF; bpc = 32'h0; rpc = 32'h0; jpc = 32'h0;
    step;
    step;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b exp 0", imem_req); end
    checks++; if (fetch_stall !== 1'b1) begin errors++; $display("FAIL reset_fstall got %0b exp 1", fetch_stall); end
    checks++; if (if_inst !== NOP) begin errors++; $display("FAIL reset_inst got %h exp %h", if_inst, NOP); end
    checks++; if (if_pc4 !== 32'h4) begin errors++; $display("FAIL reset_pc4 got %h exp 4", if_pc4); end
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b exp 0", fetch_err); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", imem_addr); end
  endtask

  task automatic test_zero_wait;
    logic [31:0] a;
    do_reset;
    for (int i = 0; i < 4; i++) begin
      a = 32'(i * 4);
      imem_ack = 1'b1; imem_rdata = mem_word(a);
      #1;
      checks++; if (imem_addr !== a) begin errors++; $display("FAIL zw_addr got %h exp %h", imem_addr, a); end
      checks++; if (if_pc4 !== a + 32'd4) begin errors++; $display("FAIL zw_pc4 got %h exp %h", if_pc4, a + 32'd4); end
      checks++; if (fetch_stall !== 1'b0) begin errors++; $display("FAIL zw_fstall got %0b exp 0", fetch_stall); end
      checks++; if (if_inst !== mem_word(a)) begin errors++; $display("FAIL zw_inst got %h exp %h", if_inst, mem_word(a)); end
      step;
    end
  endtask

  task automatic test_wait_states;
    do_reset;
    for (int i = 0; i < 3; i++) begin
      imem_ack = 1'b0; imem_rdata = 32'hBAD0_BAD0;
      #1;
      checks++; if (fetch_stall !== 1'b1) begin errors++; $display("FAIL ws_fstall got %0b exp 1", fetch_stall); end
      checks++; if (if_inst !== NOP) begin errors++; $display("FAIL ws_nop got %h exp %h", if_inst, NOP); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL ws_req got %0b/%h exp 1/0", imem_req, imem_addr); end
      step;
    end
    imem_ack = 1'b1; imem_rdata = 32'h2002_0005;
    #1;
    checks++; if (if_inst !== 32'h2002_0005) begin errors++; $display("FAIL ws_inst got %h exp 20020005", if_inst); end
    checks++; if (fetch_stall !== 1'b0) begin errors++; $display("FAIL ws_ack_fstall got %0b exp 0", fetch_stall); end
    step;
    imem_ack = 1'b0;
    #1;
    checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL ws_next_addr got %h exp 4", imem_addr); end
  endtask

  task automatic test_branch;
    do_reset;
    for (int i = 0; i < 2; i++) begin
      imem_ack = 1'b1; imem_rdata = mem_word(32'(i * 4));
      step;
    end
    imem_ack = 1'b1; pcsrc = 2'b01; bpc = 32'h0000_0040;
    #1;
    checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL br_at8 got %h exp 8", imem_addr); end
    step;
    bpc = 32'h0000_0043;
    #1;
    checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL br_target got %h exp 40", imem_addr); end
    step;
    pcsrc = 2'b00;
    #1;
    checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL br_lowbits got %h exp 40", imem_addr); end
    checks++; if (if_pc4 !== 32'h44) begin errors++; $display("FAIL br_pc4 got %h exp 44", if_pc4); end
    step;
  endtask

  task automatic test_hold;
    do_reset;
    for (int i = 0; i < 4; i++) begin
      imem_ack = 1'b1; imem_rdata = mem_word(32'(i * 4));
      step;
    end
    imem_ack = 1'b1; imem_rdata = 32'hAC01_0000; stall = 1'b1;
    #1;
    checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL hold_addr got %h exp 10", imem_addr); end
    step;
    for (int i = 0; i < 4; i++) begin
      stall = (i < 3); imem_ack = 1'b1; imem_rdata = 32'h5555_AAAA;
      pcsrc = 2'b00;
      #1;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hold_req got %0b exp 0", imem_req); end
      checks++; if (if_inst !== 32'hAC01_0000) begin errors++; $display("FAIL hold_inst got %h exp ac010000", if_inst); end
      checks++; if (if_pc4 !== 32'h14) begin errors++; $display("FAIL hold_pc4 got %h exp 14", if_pc4); end
      checks++; if (fetch_stall !== 1'b0) begin errors++; $display("FAIL hold_fstall got %0b exp 0", fetch_stall); end
      step;
    end
    imem_ack = 1'b0; stall = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin errors++; $display("FAIL hold_release got %0b/%h exp 1/14", imem_req, imem_addr); end
  endtask

  task automatic test_timeout;
    do_reset;
    for (int c = 1; c <= 16; c++) begin
      imem_ack = 1'b0; imem_rdata = 32'h1234_5678;
      #1;
      checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL to_err_early got %0b exp 0 cyc %0d", fetch_err, c); end
      if (c < 16) begin
        checks++; if (fetch_stall !== 1'b1) begin errors++; $display("FAIL to_wait got %0b exp 1 cyc %0d", fetch_stall, c); end
      end else begin
        checks++; if (fetch_stall !== 1'b0) begin errors++; $display("FAIL to_fstall got %0b exp 0", fetch_stall); end
        checks++; if (if_inst !== NOP) begin errors++; $display("FAIL to_inst got %h exp %h", if_inst, NOP); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL to_addr got %h exp 0", imem_addr); end
      end
      step;
    end
    for (int i = 0; i < 3; i++) begin
      imem_ack = 1'b1; imem_rdata = mem_word(32'(4 + i * 4));
      #1;
      checks++; if (fetch_err !== 1'b1) begin errors++; $display("FAIL to_sticky got %0b exp 1", fetch_err); end
      checks++; if (imem_addr !== 32'(4 + i * 4)) begin errors++; $display("FAIL to_advance got %h exp %h", imem_addr, 32'(4 + i * 4)); end
      step;
    end
  endtask

  task automatic test_reset_mid_fetch;
    do_reset;
    for (int i = 0; i < 8; i++) begin
      imem_ack = 1'b1; imem_rdata = mem_word(32'(i * 4));
      step;
    end
    imem_ack = 1'b0;
    #1;
    checks++; if (imem_addr !== 32'h20) begin errors++; $display("FAIL rm_at20 got %h exp 20", imem_addr); end
    step;
    clrn = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step;
    clrn = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rm_req got %0b exp 0", imem_req); end
    checks++; if (if_inst !== NOP || fetch_stall !== 1'b1) begin errors++; $display("FAIL rm_idle got %h/%0b exp %h/1", if_inst, fetch_stall, NOP); end
    checks++; if (if_pc4 !== 32'h4) begin errors++; $display("FAIL rm_pc4 got %h exp 4", if_pc4); end
    step;
    imem_ack = 1'b1; imem_rdata = mem_word(32'h0);
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL rm_restart got %0b/%h exp 1/0", imem_req, imem_addr); end
    checks++; if (if_inst !== mem_word(32'h0)) begin errors++; $display("FAIL rm_inst got %h exp %h", if_inst, mem_word(32'h0)); end
    step;
  endtask

  // Reference: the fetch stream is a sequence of addresses; each delivered
  // word is consumed on the first cycle stall is low, and consumption picks
  // the next address from pcsrc at that moment.
  task automatic test_random;
    logic [31:0] exp_addr, held_inst, nxt;
    logic [1:0]  sel;
    logic        s, a;
    int          wait_left;
    bit          pending;
    do_reset;
    exp_addr = 32'h0; pending = 0; held_inst = 32'h0;
    wait_left = $urandom_range(0, 5);
    for (int n = 0; n < 400; n++) begin
      s = ($urandom_range(0, 3) == 0);
      sel = 2'($urandom_range(0, 3));
      bpc = $urandom; rpc = $urandom; jpc = $urandom;
      stall = s; pcsrc = sel;
      if (!pending) begin
        a = (wait_left == 0);
        imem_ack = a;
        imem_rdata = a ? mem_word(exp_addr) : $urandom;
      end else begin
        a = 1'b0;
        imem_ack = 1'($urandom_range(0, 1));
        imem_rdata = $urandom;
      end
      #1;
      case (sel)
        2'b00:   nxt = exp_addr + 32'd4;
        2'b01:   nxt = bpc & 32'hFFFF_FFFC;
        2'b10:   nxt = rpc & 32'hFFFF_FFFC;
        default: nxt = jpc & 32'hFFFF_FFFC;
      endcase
      checks++; if (if_pc4 !== exp_addr + 32'd4) begin errors++; $display("FAIL rnd_pc4 n=%0d got %h exp %h", n, if_pc4, exp_addr + 32'd4); end
      if (!pending) begin
        checks++; if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin errors++; $display("FAIL rnd_addr n=%0d got %0b/%h exp 1/%h", n, imem_req, imem_addr, exp_addr); end
        checks++; if (fetch_stall !== !a) begin errors++; $display("FAIL rnd_fstall n=%0d got %0b exp %0b", n, fetch_stall, !a); end
        checks++; if (if_inst !== (a ? mem_word(exp_addr) : NOP)) begin errors++; $display("FAIL rnd_inst n=%0d got %h exp %h", n, if_inst, a ? mem_word(exp_addr) : NOP); end
        if (a) begin
          if (s) begin
            pending = 1; held_inst = mem_word(exp_addr);
          end else begin
            exp_addr = nxt; wait_left = $urandom_range(0, 5);
          end
        end else begin
          wait_left--;
        end
      end else begin
        checks++; if (imem_req !== 1'b0 || fetch_stall !== 1'b0) begin errors++; $display("FAIL rnd_hold n=%0d got %0b/%0b exp 0/0", n, imem_req, fetch_stall); end
        checks++; if (if_inst !== held_inst) begin errors++; $display("FAIL rnd_hold_inst n=%0d got %h exp %h", n, if_inst, held_inst); end
        if (!s) begin
          pending = 0; exp_addr = nxt; wait_left = $urandom_range(0, 5);
        end
      end
      step;
    end
    stall = 1'b0; pcsrc = 2'b00;
  endtask

  initial begin
    test_reset;
    test_zero_wait;
    test_wait_states;
    test_branch;
    test_hold;
    test_timeout;
    test_reset_mid_fetch;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
